alu16_lp_sched: RTL and testbench
=================================

# alu16_lp_sched

Round-robin scheduler that shares one `alu16_lp` low-power registered ALU among `NREQ` requesters. Each requester presents an opcode and operands with a valid/ready handshake. The block grants one requester at a time and pulses the ALU enable for exactly one cycle per operation, so the ALU is gated off whenever no work is pending. It then returns the registered result to the winning requester over a single response channel. It sits between the requester fabric and the ALU's `en/a/b/s/yout/carry` pins.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, 2: requester ID width, `clog2(NREQ)`.
- `CNT_W`, 16: width of the completed-operation counter.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept, one-hot or zero.
- `req_a`  in  16*NREQ  operand A; requester k uses bits [16k+15:16k].
- `req_b`  in  16*NREQ  operand B, same packing as `req_a`.
- `req_s`  in  4*NREQ  opcode; requester k uses bits [4k+3:4k].
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  IDW  index of the requester that owns the response.
- `rsp_y`  out  16  ALU result.
- `rsp_carry`  out  1  ALU carry.
- `alu_en`  out  1  to ALU `en`.
- `alu_a`, `alu_b`  out  16 each  to ALU `a` and `b`.
- `alu_s`  out  4  to ALU `s`.
- `alu_yout`  in  16  from ALU `yout`.
- `alu_carry`  in  1  from ALU `carry`.
- `busy`  out  1  high in any state other than IDLE.
- `op_count`  out  CNT_W  number of completed responses; saturates at all-ones.

## Operation
- ALU contract: `yout` and `carry` are registered on the `clk` edge at which `en`=1. They hold their value while `en`=0.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - If any `req_valid` bit is set, select the winner `w` by round-robin. The search starts at pointer `rr` and goes upward, wrapping from NREQ-1 to 0.
  - `req_ready[w]`=1 combinationally in that same cycle.
  - At the clock edge, latch `req_a/b/s[w]` into the issue registers and `w` into the ID register, then go to ISSUE.
  - If no `req_valid` bit is set, `req_ready`=0 and the FSM stays in IDLE.
- ISSUE:
  - `alu_en`=1 for exactly this cycle; `alu_a/b/s` come from the issue registers.
  - At the edge, go to CAPTURE.
- CAPTURE:
  - `alu_yout` and `alu_carry` now hold the result.
  - At the edge, latch them into `rsp_y` and `rsp_carry`, then go to RESP.
- RESP:
  - `rsp_valid`=1, and `rsp_id/y/carry` are held stable until `rsp_ready`=1.
  - On the edge where `rsp_valid && rsp_ready`:
    - go to IDLE;
    - set `rr` to (w+1) mod NREQ;
    - increment `op_count`, unless it is already all-ones.
- `req_ready` is 0 in every state except IDLE. Requests arriving while the block is busy wait; they are never dropped.
- Low-power rules:
  - `alu_a/b/s` change only on the edge that enters ISSUE. They hold their last value at all other times, including IDLE, so no operand toggling is caused by unselected requesters.
  - `alu_en`=0 in every state except ISSUE.
- A requester must hold `req_a/b/s` and `req_valid` stable until it sees `req_ready`. The scheduler samples them only in the grant cycle.

## Timing
- Reset:
  - state=IDLE, `rr`=0, `op_count`=0, `busy`=0.
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_y`=0, `rsp_carry`=0.
  - `alu_en`=0, `alu_a`=0, `alu_b`=0, `alu_s`=0.
- Reset asserted mid-operation: the FSM aborts immediately to IDLE and no response is produced. The in-flight operation is lost, and the requester has already been acknowledged.
- Latency: a grant in cycle T gives `alu_en` high in T+1, capture in T+2, and `rsp_valid` first high in T+3.
- Throughput: with `rsp_ready` tied high, one operation every 4 cycles.
- Back-to-back: the cycle after a response handshake is IDLE, so a new grant is possible then.
- All requesters valid: grants rotate 0,1,2,3,0,... with no requester starved. Worst-case wait is NREQ operations.
- `rsp_ready` low: RESP holds indefinitely. `alu_en` stays 0 and no new grant is made.
- `op_count` at all-ones stays at all-ones on further completions.

## Test plan
- Single request: after reset, requester 2 sends a=0x1234, b=0x0F0F, s=ADD.
  - `req_ready`=4'b0100 in the same cycle.
  - `alu_en` is high in exactly one cycle.
  - `rsp_valid` is high 3 cycles after the grant, with `rsp_id`=2, `rsp_y`=0x2143, `rsp_carry`=0.
  - `op_count`=1.
- Fairness: all 4 requesters are held valid with `rsp_ready`=1.
  - Grant order is 0,1,2,3,0,1,2,3 over 8 operations.
  - Grants occur every 4 cycles.
  - Each `rsp_id` matches the granted requester.
- Backpressure: hold `rsp_ready`=0 for 10 cycles while requesters 1 and 3 are valid.
  - `rsp_valid` and `rsp_y` stay stable.
  - `req_ready`=0 throughout and `alu_en`=0 throughout.
  - After release, requester 3 is granted next if `rr` points past 1.
- Operand gating: toggle `req_a/b` of a non-granted requester every cycle during IDLE and RESP.
  - `alu_a`, `alu_b` and `alu_s` show zero toggles.
  - `alu_en` pulses only in ISSUE.
- Reset mid-operation: assert `rst` during CAPTURE.
  - All outputs return to their reset values asynchronously.
  - No `rsp_valid` appears.
  - `op_count`=0 and `rr`=0.
- Saturation: run with `CNT_W`=4 and 17 completed operations; `op_count` ends at 4'hF.

Source files
------------

// File: rtl/alu16_lp_sched.sv
// Round-robin scheduler sharing one registered low-power ALU among NREQ requesters; grant->rsp_valid is 3 cycles.
// rsp_ready low holds the response and blocks new grants; waiting requests are never dropped.
module alu16_lp_sched #(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    input  logic [4*NREQ-1:0]    req_s,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_y,
    output logic                 rsp_carry,
    output logic                 alu_en,
    output logic [15:0]          alu_a,
    output logic [15:0]          alu_b,
    output logic [3:0]           alu_s,
    input  logic [15:0]          alu_yout,
    input  logic                 alu_carry,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    logic [1:0]     state;
    logic [IDW-1:0] rr;
    logic [IDW-1:0] win;
    logic           win_any;
    logic [15:0]    sel_a;
    logic [15:0]    sel_b;
    logic [3:0]     sel_s;
    logic [IDW-1:0] rr_next;

    // Search downward from the farthest offset so the nearest valid requester at or after rr wins.
    always_comb begin
        win     = '0;
        win_any = 1'b0;
        sel_a   = '0;
        sel_b   = '0;
        sel_s   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            int cand;
            cand = int'(rr) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (req_valid[cand[IDW-1:0]]) begin
                win     = cand[IDW-1:0];
                win_any = 1'b1;
                sel_a   = req_a[16*cand +: 16];
                sel_b   = req_b[16*cand +: 16];
                sel_s   = req_s[4*cand +: 4];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && state == S_IDLE && win_any) begin
            req_ready[win] = 1'b1;
        end
    end

    assign rr_next   = (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + IDW'(1);
    assign alu_en    = (state == S_ISSUE);
    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);

    // Issue registers double as the ALU operand pins, so they only move on a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rr        <= '0;
            op_count  <= '0;
            rsp_id    <= '0;
            rsp_y     <= '0;
            rsp_carry <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_any) begin
                        alu_a  <= sel_a;
                        alu_b  <= sel_b;
                        alu_s  <= sel_s;
                        rsp_id <= win;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    rsp_y     <= alu_yout;
                    rsp_carry <= alu_carry;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                        rr    <= rr_next;
                        if (op_count != {CNT_W{1'b1}}) begin
                            op_count <= op_count + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu16_lp_sched.sv
// Scoreboard bench for alu16_lp_sched with a behavioural registered ALU; a CNT_W=4 copy shares the stimulus.
module tb_alu16_lp_sched;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid;
    logic [16*NREQ-1:0] req_a;
    logic [16*NREQ-1:0] req_b;
    logic [4*NREQ-1:0] req_s;
    logic              rsp_ready;

    logic [NREQ-1:0] req_ready, req_ready2;
    logic            rsp_valid, rsp_valid2;
    logic [1:0]      rsp_id, rsp_id2;
    logic [15:0]     rsp_y, rsp_y2;
    logic            rsp_carry, rsp_carry2;
    logic            alu_en, alu_en2;
    logic [15:0]     alu_a, alu_b, alu_a2, alu_b2;
    logic [3:0]      alu_s, alu_s2;
    logic            busy, busy2;
    logic [15:0]     op_count;
    logic [3:0]      op_count2;

    logic [15:0] alu_y1 = '0;
    logic [15:0] alu_y2 = '0;
    logic        alu_c1 = 1'b0;
    logic        alu_c2 = 1'b0;

    always #5 clk = ~clk;

    alu16_lp_sched #(.NREQ(4), .IDW(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_s(req_s),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_carry(rsp_carry),
        .alu_en(alu_en), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_yout(alu_y1), .alu_carry(alu_c1), .busy(busy), .op_count(op_count)
    );

    alu16_lp_sched #(.NREQ(4), .IDW(2), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
        .req_a(req_a), .req_b(req_b), .req_s(req_s),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_id(rsp_id2),
        .rsp_y(rsp_y2), .rsp_carry(rsp_carry2),
        .alu_en(alu_en2), .alu_a(alu_a2), .alu_b(alu_b2), .alu_s(alu_s2),
        .alu_yout(alu_y2), .alu_carry(alu_c2), .busy(busy2), .op_count(op_count2)
    );

    // Opcodes: 0 add, 1 sub (carry = borrow), 2 and, 3 or, 4 xor, others pass A.
    function automatic logic [16:0] alu_f(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
        case (s)
            4'd0:    return {1'b0, a} + {1'b0, b};
            4'd1:    return {(a < b), a - b};
            4'd2:    return {1'b0, a & b};
            4'd3:    return {1'b0, a | b};
            4'd4:    return {1'b0, a ^ b};
            default: return {1'b0, a};
        endcase
    endfunction

    always @(posedge clk) begin
        if (alu_en)  {alu_c1, alu_y1} <= alu_f(alu_s, alu_a, alu_b);
        if (alu_en2) {alu_c2, alu_y2} <= alu_f(alu_s2, alu_a2, alu_b2);
    end

    int nchk = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [1:0]  id;
        logic        c;
        logic [15:0] y;
    } exp_t;

    exp_t        sb[$];
    int          hist[$];
    int          hcyc[$];
    logic        in_flight = 1'b0;
    int          rr_m = 0;
    int          cnt_m = 0;
    int          ncyc = 0;
    int          gcyc = -10;
    int          toggles = 0;
    int          en_cnt = 0;
    logic [15:0] last_y = '0;
    logic [15:0] iss_a = '0, iss_b = '0;
    logic [3:0]  iss_s = '0;
    logic [15:0] prev_a = '0, prev_b = '0, prev_y = '0;
    logic [3:0]  prev_s = '0;
    logic [1:0]  prev_id = '0;
    logic        prev_vld = 1'b0, prev_hs = 1'b0;
    logic [3:0]  gnt_mask = '0;

    // Reference model and scoreboard, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            in_flight = 1'b0; rr_m = 0; cnt_m = 0; gcyc = -10;
            sb.delete(); gnt_mask = '0;
            prev_a = '0; prev_b = '0; prev_s = '0; prev_vld = 1'b0; prev_hs = 1'b0;
        end else begin
            logic [3:0] exp_rdy;
            logic       en_e, hs;
            int         wk;
            ncyc++;
            exp_rdy = '0;
            wk = -1;
            if (!in_flight) begin
                for (int i = NREQ - 1; i >= 0; i--) begin
                    if (req_valid[(rr_m + i) % NREQ]) wk = (rr_m + i) % NREQ;
                end
            end
            if (wk >= 0) exp_rdy[wk] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);
            chk("req_ready_sat", req_ready2, exp_rdy);
            chk("busy", busy, in_flight && ncyc > gcyc);
            en_e = in_flight && ncyc == gcyc + 1;
            chk("alu_en", alu_en, en_e);
            if (alu_en) en_cnt++;
            chk("rsp_valid", rsp_valid, in_flight && ncyc >= gcyc + 3);
            if (en_e) begin
                chk("issue_a", alu_a, iss_a);
                chk("issue_b", alu_b, iss_b);
                chk("issue_s", alu_s, iss_s);
            end else begin
                if (alu_a !== prev_a || alu_b !== prev_b || alu_s !== prev_s) toggles++;
                chk("hold_a", alu_a, prev_a);
                chk("hold_b", alu_b, prev_b);
                chk("hold_s", alu_s, prev_s);
            end
            prev_a = alu_a; prev_b = alu_b; prev_s = alu_s;
            if (rsp_valid && prev_vld && !prev_hs) begin
                chk("rsp_y_stable", rsp_y, prev_y);
                chk("rsp_id_stable", rsp_id, prev_id);
            end
            chk("op_count", op_count, cnt_m);
            hs = rsp_valid && rsp_ready;
            if (hs) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", rsp_valid, 1'b0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_y", rsp_y, e.y);
                    chk("rsp_carry", rsp_carry, e.c);
                    rr_m = (int'(e.id) + 1) % NREQ;
                end
                cnt_m++;
                in_flight = 1'b0;
                last_y = rsp_y;
            end
            if (wk >= 0) begin
                exp_t e;
                logic [16:0] r;
                in_flight = 1'b1;
                gcyc = ncyc;
                iss_a = req_a[16*wk +: 16];
                iss_b = req_b[16*wk +: 16];
                iss_s = req_s[4*wk +: 4];
                r = alu_f(iss_s, iss_a, iss_b);
                e.id = 2'(wk); e.c = r[16]; e.y = r[15:0];
                sb.push_back(e);
                hist.push_back(wk);
                hcyc.push_back(ncyc);
            end
            gnt_mask = exp_rdy;
            prev_vld = rsp_valid; prev_hs = hs; prev_y = rsp_y; prev_id = rsp_id;
        end
    end

    int   quota[NREQ];
    logic toggle_on = 1'b0;

    task automatic rand_op(input int k);
        req_a[16*k +: 16] = 16'($urandom);
        req_b[16*k +: 16] = 16'($urandom);
        req_s[4*k +: 4]   = 4'($urandom_range(0, 5));
        req_valid[k]      = 1'b1;
    endtask

    // One clock of stimulus: retire granted requests and optionally wiggle idle requester 0.
    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_mask[k]) begin
                quota[k]--;
                if (quota[k] > 0) rand_op(k);
                else req_valid[k] = 1'b0;
            end
        end
        if (toggle_on) begin
            req_a[15:0] = ~req_a[15:0];
            req_b[15:0] = req_b[15:0] + 16'd1;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((|req_valid || in_flight || sb.size() > 0 || busy) && n < budget) begin
            step();
            n++;
        end
        chk("drain_done", {31'd0, (|req_valid || in_flight || busy)}, 32'd0);
    endtask

    task automatic check_hist(input string tag, input int exp_q[$]);
        chk({tag, "_len"}, hist.size(), exp_q.size());
        if (hist.size() == exp_q.size()) begin
            for (int i = 0; i < exp_q.size(); i++) chk(tag, hist[i], exp_q[i]);
        end
    endtask

    task automatic wait_rsp_valid(input string tag);
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        chk(tag, rsp_valid, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 4'h0);
        chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_alu_en"}, alu_en, 1'b0);
        chk({tag, "_alu_a"}, alu_a, 16'h0);
        chk({tag, "_alu_b"}, alu_b, 16'h0);
        chk({tag, "_alu_s"}, alu_s, 4'h0);
        chk({tag, "_rsp_id"}, rsp_id, 2'h0);
        chk({tag, "_rsp_y"}, rsp_y, 16'h0);
        chk({tag, "_rsp_carry"}, rsp_carry, 1'b0);
        chk({tag, "_op_count"}, op_count, 16'h0);
    endtask

    initial begin
        int n;
        req_valid = '0; req_a = '0; req_b = '0; req_s = '0; rsp_ready = 1'b1;
        for (int k = 0; k < NREQ; k++) quota[k] = 0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single ADD from requester 2.
        step();
        req_a[32 +: 16] = 16'h1234;
        req_b[32 +: 16] = 16'h0F0F;
        req_s[8 +: 4]   = 4'd0;
        req_valid[2]    = 1'b1;
        quota[2]        = 1;
        @(negedge clk);
        chk("single_ready", req_ready, 4'b0100);
        drain(40);
        chk("single_y", last_y, 16'h2143);
        chk("single_en_pulses", en_cnt, 1);
        chk("single_op_count", op_count, 16'd1);

        // Fairness: all requesters valid, rr starts at 3 after the single op.
        hist.delete(); hcyc.delete();
        for (int k = 0; k < NREQ; k++) begin
            quota[k] = 2;
            rand_op(k);
        end
        drain(200);
        check_hist("fair_order", '{3, 0, 1, 2, 3, 0, 1, 2});
        for (int i = 1; i < hcyc.size(); i++) chk("fair_interval", hcyc[i] - hcyc[i-1], 4);

        // Backpressure: hold requester 1's response while 1 and 3 wait.
        hist.delete();
        rsp_ready = 1'b0;
        quota[1] = 1;
        rand_op(1);
        wait_rsp_valid("bp_rsp_reached");
        quota[1] = 1; rand_op(1);
        quota[3] = 1; rand_op(3);
        repeat (10) step();
        rsp_ready = 1'b1;
        drain(100);
        check_hist("bp_order", '{1, 3, 1});

        // Operand gating with idle requester 0 toggling every cycle.
        toggles = 0;
        toggle_on = 1'b1;
        quota[2] = 2;
        rand_op(2);
        rsp_ready = 1'b0;
        wait_rsp_valid("gate_rsp_reached");
        repeat (3) step();
        rsp_ready = 1'b1;
        drain(100);
        toggle_on = 1'b0;
        chk("gate_toggles", toggles, 0);

        // Reset during CAPTURE.
        quota[1] = 1;
        rand_op(1);
        n = 0;
        while (!alu_en && n < 20) begin
            step();
            n++;
        end
        chk("rst_issue_reached", alu_en, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        step();
        step();
        rst = 1'b0;
        repeat (8) step();
        chk("midrst_no_rsp", rsp_valid, 1'b0);
        hist.delete();
        quota[1] = 1; rand_op(1);
        quota[3] = 1; rand_op(3);
        drain(100);
        check_hist("midrst_rr", '{1, 3});

        // Saturation of the CNT_W=4 copy: 20 more completions after the reset.
        for (int k = 0; k < NREQ; k++) begin
            quota[k] = 5;
            rand_op(k);
        end
        drain(400);
        chk("final_op_count", op_count, 16'd22);
        chk("sat_op_count", op_count2, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
